// File: rtl/rc4_stream_core.sv
// rc4_stream_core
//   Variable-length-key RC4 stream cipher engine with optional RC4-drop[N].
//   Sequence per session: IDLE -> KEY_LOAD -> INIT -> KSA -> (DROP) -> STREAM,
//   and back to IDLE only through STOP_IN or RESET_IN.
//
// Ports
//   CLK_IN, RESET_IN        : rising-edge clock, synchronous active-high reset
//   START_IN, STOP_IN       : session start (IDLE only) / abort from any state
//   KEY_SIZE_IN, DROP_N_IN  : key length and drop count, latched with START_IN
//   KEY_VALID_IN/KEY_BYTE_IN/KEY_READY_OUT : key byte handshake, K[0] first
//   IN_VALID_IN/IN_BYTE_IN/IN_READY_OUT    : input byte handshake
//   OUT_VALID_OUT/ENC_BYTE_OUT/OUT_READY_IN: output byte handshake
//   BUSY_OUT                : high whenever not IDLE
//   KEY_ERR_OUT             : one-cycle pulse after a START with a bad key size
module rc4_stream_core #(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_W        = 16
) (
  input  logic              CLK_IN,
  input  logic              RESET_IN,
  input  logic              START_IN,
  input  logic              STOP_IN,
  input  logic [7:0]        KEY_SIZE_IN,
  input  logic [DROP_W-1:0] DROP_N_IN,
  input  logic              KEY_VALID_IN,
  input  logic [7:0]        KEY_BYTE_IN,
  output logic              KEY_READY_OUT,
  input  logic              IN_VALID_IN,
  input  logic [7:0]        IN_BYTE_IN,
  output logic              IN_READY_OUT,
  output logic              OUT_VALID_OUT,
  output logic [7:0]        ENC_BYTE_OUT,
  input  logic              OUT_READY_IN,
  output logic              BUSY_OUT,
  output logic              KEY_ERR_OUT
);

  localparam int          KIDX_W    = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
  localparam logic [31:0] MAX_KEY_U = 32'(MAX_KEY_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY_LOAD, ST_INIT, ST_KSA, ST_DROP, ST_STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         i_q, i_d, j_q, j_d;
  logic [KIDX_W-1:0]  kc_q, kc_d;
  logic [7:0]         key_len_q, key_len_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [7:0]         enc_q, enc_d;
  logic               out_valid_q, out_valid_d;
  logic               key_err_q, key_err_d;

  logic [7:0]         sbox_q [256];
  logic [7:0]         key_q  [MAX_KEY_BYTES];

  logic               start_ok, kc_last, key_fire, in_ready, in_fire;
  logic [7:0]         s_i, key_byte, ksa_j, ksa_sj;
  logic [7:0]         prga_i, prga_j, s_pi, s_pj, ks_idx, ks_byte;
  logic               sbox_we;
  logic [7:0]         wa_addr, wa_data, wb_addr, wb_data;

  // Shared handshake qualifiers and the KSA / PRGA read paths.
  // kc_q doubles as the key-load index and the KSA key index (wraps at L).
  always_comb begin
    start_ok = (KEY_SIZE_IN != 8'd0) && ({24'd0, KEY_SIZE_IN} <= MAX_KEY_U);
    kc_last  = (8'(kc_q) == key_len_q - 8'd1);
    key_fire = (state_q == ST_KEY_LOAD) && KEY_VALID_IN && !STOP_IN;
    in_ready = (state_q == ST_STREAM) && !STOP_IN && (!out_valid_q || OUT_READY_IN);
    in_fire  = in_ready && IN_VALID_IN;

    s_i      = sbox_q[i_q];
    key_byte = key_q[kc_q];
    ksa_j    = j_q + s_i + key_byte;
    ksa_sj   = sbox_q[ksa_j];

    prga_i   = i_q + 8'd1;
    s_pi     = sbox_q[prga_i];
    prga_j   = j_q + s_pi;
    s_pj     = sbox_q[prga_j];
    // The index sum is swap-invariant; only the final lookup must see the
    // post-swap table, so redirect reads that land on a swapped entry.
    ks_idx   = s_pi + s_pj;
    if (ks_idx == prga_i) begin
      ks_byte = s_pj;
    end else if (ks_idx == prga_j) begin
      ks_byte = s_pi;
    end else begin
      ks_byte = sbox_q[ks_idx];
    end
  end

  // Next-state logic; STOP_IN overrides everything, including START_IN.
  always_comb begin
    state_d = state_q;
    if (STOP_IN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (START_IN && start_ok) state_d = ST_KEY_LOAD;
        ST_KEY_LOAD: if (key_fire && kc_last) state_d = ST_INIT;
        ST_INIT:     if (i_q == 8'hFF) state_d = ST_KSA;
        ST_KSA:      if (i_q == 8'hFF) state_d = (drop_q != '0) ? ST_DROP : ST_STREAM;
        ST_DROP:     if (drop_q == DROP_W'(1)) state_d = ST_STREAM;
        ST_STREAM:   state_d = ST_STREAM;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: counters, S-box write ports and the output register.
  // Both write ports carry the same entry during INIT; on a self-swap they
  // also coincide, so dual writes to one address never conflict.
  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    kc_d        = kc_q;
    key_len_d   = key_len_q;
    drop_d      = drop_q;
    enc_d       = enc_q;
    out_valid_d = out_valid_q;
    key_err_d   = 1'b0;
    sbox_we     = 1'b0;
    wa_addr     = i_q;
    wa_data     = i_q;
    wb_addr     = i_q;
    wb_data     = i_q;

    if (STOP_IN) begin
      if (state_q != ST_IDLE) begin
        i_d         = 8'd0;
        j_d         = 8'd0;
        kc_d        = '0;
        drop_d      = '0;
        out_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START_IN) begin
            if (start_ok) begin
              key_len_d = KEY_SIZE_IN;
              drop_d    = DROP_N_IN;
              kc_d      = '0;
            end else begin
              key_err_d = 1'b1;
            end
          end
        end
        ST_KEY_LOAD: begin
          if (key_fire) begin
            if (kc_last) begin
              kc_d = '0;
              i_d  = 8'd0;
            end else begin
              kc_d = kc_q + 1'b1;
            end
          end
        end
        ST_INIT: begin
          sbox_we = 1'b1;
          i_d     = i_q + 8'd1;
          if (i_q == 8'hFF) begin
            j_d  = 8'd0;
            kc_d = '0;
          end
        end
        ST_KSA: begin
          sbox_we = 1'b1;
          wa_data = ksa_sj;
          wb_addr = ksa_j;
          wb_data = s_i;
          kc_d    = kc_last ? '0 : kc_q + 1'b1;
          if (i_q == 8'hFF) begin
            i_d = 8'd0;
            j_d = 8'd0;
          end else begin
            i_d = i_q + 8'd1;
            j_d = ksa_j;
          end
        end
        ST_DROP: begin
          sbox_we = 1'b1;
          wa_addr = prga_i;
          wa_data = s_pj;
          wb_addr = prga_j;
          wb_data = s_pi;
          i_d     = prga_i;
          j_d     = prga_j;
          drop_d  = drop_q - DROP_W'(1);
        end
        ST_STREAM: begin
          if (in_fire) begin
            sbox_we     = 1'b1;
            wa_addr     = prga_i;
            wa_data     = s_pj;
            wb_addr     = prga_j;
            wb_data     = s_pi;
            i_d         = prga_i;
            j_d         = prga_j;
            enc_d       = IN_BYTE_IN ^ ks_byte;
            out_valid_d = 1'b1;
          end else if (OUT_READY_IN) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          i_d = 8'd0;
        end
      endcase
    end
  end

  // Output decode; ready lines drop in the STOP cycle so nothing is accepted.
  always_comb begin
    KEY_READY_OUT = (state_q == ST_KEY_LOAD) && !STOP_IN;
    IN_READY_OUT  = in_ready;
    OUT_VALID_OUT = out_valid_q;
    ENC_BYTE_OUT  = enc_q;
    BUSY_OUT      = (state_q != ST_IDLE);
    KEY_ERR_OUT   = key_err_q;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q     <= ST_IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      kc_q        <= '0;
      key_len_q   <= 8'd0;
      drop_q      <= '0;
      enc_q       <= 8'd0;
      out_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      kc_q        <= kc_d;
      key_len_q   <= key_len_d;
      drop_q      <= drop_d;
      enc_q       <= enc_d;
      out_valid_q <= out_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  // Storage arrays are never cleared; INIT rewrites the whole S-box.
  always_ff @(posedge CLK_IN) begin
    if (sbox_we && !RESET_IN) begin
      sbox_q[wa_addr] <= wa_data;
      sbox_q[wb_addr] <= wb_data;
    end
    if (key_fire && !RESET_IN) begin
      key_q[kc_q] <= KEY_BYTE_IN;
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb_rc4_stream_core
//   Directed-vector bench for rc4_stream_core. Stimulus pushes the expected
//   output byte into a queue when the DUT accepts an input byte; a monitor
//   pops and compares on every output handshake.
module tb_rc4_stream_core;

  localparam int MAXK = 32;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          RESET_IN, START_IN, STOP_IN;
  logic [7:0]    KEY_SIZE_IN;
  logic [DW-1:0] DROP_N_IN;
  logic          KEY_VALID_IN;
  logic [7:0]    KEY_BYTE_IN;
  logic          KEY_READY_OUT;
  logic          IN_VALID_IN;
  logic [7:0]    IN_BYTE_IN;
  logic          IN_READY_OUT;
  logic          OUT_VALID_OUT;
  logic [7:0]    ENC_BYTE_OUT;
  logic          OUT_READY_IN = 1'b1;
  logic          BUSY_OUT;
  logic          KEY_ERR_OUT;

  always #5 clk = ~clk;

  rc4_stream_core #(.MAX_KEY_BYTES(MAXK), .DROP_W(DW)) dut (
    .CLK_IN(clk), .RESET_IN(RESET_IN), .START_IN(START_IN), .STOP_IN(STOP_IN),
    .KEY_SIZE_IN(KEY_SIZE_IN), .DROP_N_IN(DROP_N_IN),
    .KEY_VALID_IN(KEY_VALID_IN), .KEY_BYTE_IN(KEY_BYTE_IN), .KEY_READY_OUT(KEY_READY_OUT),
    .IN_VALID_IN(IN_VALID_IN), .IN_BYTE_IN(IN_BYTE_IN), .IN_READY_OUT(IN_READY_OUT),
    .OUT_VALID_OUT(OUT_VALID_OUT), .ENC_BYTE_OUT(ENC_BYTE_OUT), .OUT_READY_IN(OUT_READY_IN),
    .BUSY_OUT(BUSY_OUT), .KEY_ERR_OUT(KEY_ERR_OUT)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         readyMode = 0;
  logic [7:0] expQ[$];
  logic [7:0] tbKey[MAXK];
  int         tbKeyLen = 1;
  logic [7:0] modelKs[64];
  logic       holdPending = 1'b0;
  logic [7:0] heldVal = 8'h00;

  logic [7:0] expPlain[$] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] expWiki[$]  = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] expDawn[$]  = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                              8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = pseudo-random, 2 = stalled.
  always begin
    @(posedge clk);
    #1;
    case (readyMode)
      1:       OUT_READY_IN = 1'($urandom_range(0, 1));
      2:       OUT_READY_IN = 1'b0;
      default: OUT_READY_IN = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Output monitor: stability while stalled, then in-order scoreboard pop.
  always @(negedge clk) begin
    if (OUT_VALID_OUT) begin
      if (holdPending) checkOutput("enc_hold_stable", 32'(ENC_BYTE_OUT), 32'(heldVal));
      if (OUT_READY_IN) begin
        holdPending = 1'b0;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: actual=%0h required=none", ENC_BYTE_OUT);
        end else begin
          checkOutput("enc_byte", 32'(ENC_BYTE_OUT), 32'(expQ.pop_front()));
        end
      end else begin
        holdPending = 1'b1;
        heldVal     = ENC_BYTE_OUT;
      end
    end else begin
      holdPending = 1'b0;
    end
  end

  // Textbook RC4 reference: keystream of tbKey[0..keyLen-1] into modelKs.
  function automatic void rc4Model(input int keyLen, input int count);
    logic [7:0] s[256];
    logic [7:0] a, b, t;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    b = 8'd0;
    for (int k = 0; k < 256; k++) begin
      b = b + s[k] + tbKey[k % keyLen];
      t = s[k]; s[k] = s[b]; s[b] = t;
    end
    a = 8'd0;
    b = 8'd0;
    for (int n = 0; n < count; n++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      t = s[a] + s[b];
      modelKs[n] = s[t];
    end
  endfunction

  task automatic setKeyString(input string s);
    tbKeyLen = s.len();
    for (int k = 0; k < s.len(); k++) tbKey[k] = s[k];
  endtask

  // START plus back-to-back key bytes; returns at posedge+1 with startCyc.
  task automatic loadKey(input int n, output int startCyc);
    int w;
    START_IN     = 1'b1;
    KEY_SIZE_IN  = 8'(tbKeyLen);
    DROP_N_IN    = DW'(n);
    KEY_VALID_IN = 1'b1;
    KEY_BYTE_IN  = tbKey[0];
    startCyc     = cyc;
    @(posedge clk); #1;
    START_IN = 1'b0;
    for (int k = 0; k < tbKeyLen; k++) begin
      KEY_BYTE_IN = tbKey[k];
      w = 0;
      @(negedge clk);
      while (!KEY_READY_OUT && w < 100) begin @(negedge clk); w++; end
      if (!KEY_READY_OUT) checkOutput("key_ready_timeout", 32'(KEY_READY_OUT), 32'd1);
      @(posedge clk); #1;
    end
    KEY_VALID_IN = 1'b0;
  endtask

  task automatic startRun(input int n, output int latency);
    int w, sc;
    loadKey(n, sc);
    w = 0;
    @(negedge clk);
    while (!IN_READY_OUT && w < 3000) begin @(negedge clk); w++; end
    if (!IN_READY_OUT) checkOutput("in_ready_timeout", 32'(IN_READY_OUT), 32'd1);
    latency = cyc - sc;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] expect_b);
    int w;
    IN_VALID_IN = 1'b1;
    IN_BYTE_IN  = b;
    w = 0;
    @(negedge clk);
    while (!IN_READY_OUT && w < 200) begin @(negedge clk); w++; end
    if (IN_READY_OUT) expQ.push_back(expect_b);
    else checkOutput("in_accept_timeout", 32'(IN_READY_OUT), 32'd1);
    @(posedge clk); #1;
    IN_VALID_IN = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 500) begin @(negedge clk); w++; end
    checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic stopCore();
    STOP_IN = 1'b1;
    @(negedge clk);
    checkOutput("busy_before_stop", 32'(BUSY_OUT), 32'd1);
    @(posedge clk); #1;
    STOP_IN = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_stop", 32'(BUSY_OUT), 32'd0);
    checkOutput("valid_after_stop", 32'(OUT_VALID_OUT), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic runDirected(input string key, input string pt, input logic [7:0] expBytes[$]);
    int lat;
    setKeyString(key);
    startRun(0, lat);
    checkOutput({"latency_", key}, 32'(lat), 32'(1 + key.len() + 512));
    for (int k = 0; k < pt.len(); k++) applyStimulus(pt[k], expBytes[k]);
    waitDrain();
    stopCore();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_key_ready"}, 32'(KEY_READY_OUT), 32'd0);
    checkOutput({tag, "_in_ready"},  32'(IN_READY_OUT),  32'd0);
    checkOutput({tag, "_out_valid"}, 32'(OUT_VALID_OUT), 32'd0);
    checkOutput({tag, "_enc_byte"},  32'(ENC_BYTE_OUT),  32'd0);
    checkOutput({tag, "_busy"},      32'(BUSY_OUT),      32'd0);
    checkOutput({tag, "_key_err"},   32'(KEY_ERR_OUT),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat0, lat3, sc, errCnt, busyCnt, krCnt;
    logic [7:0] sz;
    RESET_IN = 1'b1; START_IN = 1'b0; STOP_IN = 1'b0;
    KEY_SIZE_IN = 8'd0; DROP_N_IN = '0; KEY_VALID_IN = 1'b0; KEY_BYTE_IN = 8'd0;
    IN_VALID_IN = 1'b0; IN_BYTE_IN = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    RESET_IN = 1'b0;
    @(posedge clk); #1;

    // Rejected key sizes: 0 and MAXK+1.
    for (int t = 0; t < 2; t++) begin
      sz = (t == 0) ? 8'd0 : 8'(MAXK + 1);
      errCnt = 0; busyCnt = 0; krCnt = 0;
      START_IN = 1'b1;
      KEY_SIZE_IN = sz;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        errCnt  += int'(KEY_ERR_OUT);
        busyCnt += int'(BUSY_OUT);
        krCnt   += int'(KEY_READY_OUT);
        @(posedge clk); #1;
        START_IN = 1'b0;
      end
      checkOutput("key_err_pulses", 32'(errCnt), 32'd1);
      checkOutput("key_err_busy", 32'(busyCnt), 32'd0);
      checkOutput("key_err_key_ready", 32'(krCnt), 32'd0);
    end

    runDirected("Key", "Plaintext", expPlain);
    runDirected("Wiki", "pedia", expWiki);
    runDirected("Secret", "Attack at dawn", expDawn);

    // Full-length key with random downstream backpressure.
    tbKeyLen = MAXK;
    for (int k = 0; k < MAXK; k++) tbKey[k] = 8'(8'hAE + k * 53);
    rc4Model(MAXK, 32);
    startRun(0, lat0);
    checkOutput("latency_key32", 32'(lat0), 32'(1 + MAXK + 512));
    readyMode = 1;
    for (int k = 0; k < 32; k++) applyStimulus(8'(8'h3A + k * 29), 8'(8'h3A + k * 29) ^ modelKs[k]);
    waitDrain();
    readyMode = 0;
    stopCore();

    // Drop mode: N=3 must skip exactly three keystream bytes.
    setKeyString("Key");
    rc4Model(3, 12);
    startRun(0, lat0);
    checkOutput("drop0_latency", 32'(lat0), 32'(1 + 3 + 512));
    for (int k = 0; k < 12; k++) applyStimulus(8'h00, modelKs[k]);
    waitDrain();
    stopCore();
    startRun(3, lat3);
    checkOutput("drop3_latency", 32'(lat3), 32'(1 + 3 + 512 + 3));
    checkOutput("drop_latency_delta", 32'(lat3 - lat0), 32'd3);
    for (int k = 0; k < 9; k++) applyStimulus(8'h00, modelKs[k + 3]);
    waitDrain();
    stopCore();

    // Abort at KSA step 100, then a clean rerun.
    setKeyString("Key");
    loadKey(0, sc);
    repeat (256 + 100) @(posedge clk);
    #1;
    stopCore();
    runDirected("Key", "Plaintext", expPlain);

    // Reset while an output is pending under stall.
    setKeyString("Key");
    startRun(0, lat0);
    readyMode = 2;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("P", expPlain[0]);
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(OUT_VALID_OUT), 32'd1);
    @(posedge clk); #1;
    RESET_IN = 1'b1;
    @(posedge clk); #1;
    RESET_IN = 1'b0;
    @(negedge clk);
    checkAllZero("mid_stream_reset");
    expQ.delete();
    readyMode = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
